onehot_encoder_reg: RTL and testbench

Registered one-hot-to-binary encoder with a valid/ready handshake on both sides. It is the inverse of the team's 2-to-4 one-hot decoder: it takes an N-bit one-hot word and returns its binary index. Malformed input (zero or multi-hot) is flagged per beat and counted in a saturating error counter. It sits on status and select buses where a one-hot source must be compressed before crossing to a binary-indexed consumer.

---
 rtl/enc_pkg.sv | 21 ++
 rtl/onehot_encoder_reg_if.sv | 33 +++
 rtl/onehot_encoder_reg_prio_enc.sv | 26 ++
 rtl/onehot_encoder_reg.sv | 81 ++++++++
 tb/tb_onehot_encoder_reg.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the one-hot encoder slice: code-width derivation,
// counter width default and the handshake state encoding.
package enc_pkg;

  function automatic int enc_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int CNT_W_DEF = 8;

  // Default one-hot width and the binary index width it maps onto.
  localparam int ENC_N = 4;
  localparam int ENC_W = enc_w(ENC_N);

  // Output register occupancy; the value doubles as out_vld.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/onehot_encoder_reg_if.sv
// Bus bundle for the registered one-hot encoder: input beat, output beat and
// error-counter control.
interface onehot_encoder_reg_if
  import enc_pkg::*;
#(
  parameter int N     = ENC_N,
  parameter int CNT_W = CNT_W_DEF
);
  localparam int W = enc_w(N);

  // A beat moves on a rising edge where vld && rdy; the producer holds vld and
  // data stable until then, and rdy may depend combinationally on the far side.
  logic             in_vld;
  logic             in_rdy;
  logic [N-1:0]     in_data;
  logic             out_vld;
  logic             out_rdy;
  logic [W-1:0]     out_code;
  logic             out_err;
  logic [CNT_W-1:0] err_cnt;
  logic             clr_err;

  modport master (
    output in_vld, in_data, out_rdy, clr_err,
    input  in_rdy, out_vld, out_code, out_err, err_cnt
  );

  modport slave (
    input  in_vld, in_data, out_rdy, clr_err,
    output in_rdy, out_vld, out_code, out_err, err_cnt
  );

endinterface

// File: rtl/onehot_encoder_reg_prio_enc.sv
// Combinational LSB-priority encoder: lowest set bit wins, with zero and
// multi-hot flags so callers can judge whether the word was strictly one-hot.
module prio_enc
  import enc_pkg::*;
#(
  parameter int N = ENC_N,
  localparam int W = enc_w(N)
) (
  input  logic [N-1:0] in_data,
  output logic [W-1:0] code,
  output logic         zero,
  output logic         multi
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    code = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_data[i]) code = W'(i);
    end
  end

  assign zero  = ~|in_data;
  assign multi = |(in_data & (in_data - N'(1)));

endmodule

// File: rtl/onehot_encoder_reg.sv
// Registered one-hot-to-binary encoder with valid/ready on both sides and a
// saturating count of accepted malformed beats.
module onehot_encoder_reg
  import enc_pkg::*;
#(
  parameter int N     = ENC_N,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  onehot_encoder_reg_if.slave bus,
  output state_e              dbg_state
);

  localparam int W = enc_w(N);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [W-1:0]     code_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic [W-1:0]     enc_code;
  logic             enc_zero, enc_multi;
  logic             accept, err_beat;

  prio_enc #(.N(N)) u_prio_enc (
    .in_data (bus.in_data),
    .code    (enc_code),
    .zero    (enc_zero),
    .multi   (enc_multi)
  );

  // No skid buffer: a full register frees up only when the consumer takes it.
  assign bus.in_rdy = (state_q == EMPTY) || bus.out_rdy;
  assign accept     = bus.in_vld && bus.in_rdy;
  assign err_beat   = accept && (enc_zero || enc_multi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (!accept && bus.out_rdy) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Code and flag keep their stale values after a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      code_q <= enc_code;
      err_q  <= enc_zero || enc_multi;
    end
  end

  // Clear outranks counting, but an error beat in the clearing cycle survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.clr_err) begin
      cnt_q <= err_beat ? CNT_W'(1) : '0;
    end else if (err_beat && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.out_vld  = (state_q == FULL);
  assign bus.out_code = code_q;
  assign bus.out_err  = err_q;
  assign bus.err_cnt  = cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_onehot_encoder_reg.sv
// Directed bench for onehot_encoder_reg at N=4, CNT_W=2: a vector table for
// encode/error/clear/saturation, plus hand sequences for stall and reset.
module tb_onehot_encoder_reg;
  import enc_pkg::*;

  localparam int N     = 4;
  localparam int CNT_W = 2;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e dbg_state;
  int     checks = 0;
  int     errors = 0;

  onehot_encoder_reg_if #(.N(N), .CNT_W(CNT_W)) bus ();

  onehot_encoder_reg #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- vectors ----------------
  typedef struct {
    logic       vld;
    logic [3:0] d;
    logic       ordy;
    logic       clr;
    logic       x_irdy;
    logic       x_vld;
    logic [1:0] x_code;
    logic       x_err;
    logic [1:0] x_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic vld, logic [3:0] d, logic ordy, logic clr,
                              logic x_irdy, logic x_vld, logic [1:0] x_code,
                              logic x_err, logic [1:0] x_cnt);
    vec_t v;
    v.vld = vld; v.d = d; v.ordy = ordy; v.clr = clr;
    v.x_irdy = x_irdy; v.x_vld = x_vld; v.x_code = x_code;
    v.x_err = x_err; v.x_cnt = x_cnt;
    return v;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic x_vld, input logic [1:0] x_code,
                         input logic x_err, input logic [1:0] x_cnt);
    chk({tag, " out_vld"},  int'(bus.out_vld),  int'(x_vld));
    chk({tag, " out_code"}, int'(bus.out_code), int'(x_code));
    chk({tag, " out_err"},  int'(bus.out_err),  int'(x_err));
    chk({tag, " err_cnt"},  int'(bus.err_cnt),  int'(x_cnt));
  endtask

  // Drive at posedge+1, check in_rdy combinationally, then outputs after the edge.
  task automatic drive(input logic vld, input logic [3:0] d, input logic ordy, input logic clr);
    bus.in_vld  = vld;
    bus.in_data = d;
    bus.out_rdy = ordy;
    bus.clr_err = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(1'b0, 4'b0000, 1'b0, 1'b0);

    // Clean encode
    tbl.push_back(mk(1, 4'b0001, 1, 0,  1, 1, 2'd0, 0, 2'd0));
    tbl.push_back(mk(1, 4'b0010, 1, 0,  1, 1, 2'd1, 0, 2'd0));
    tbl.push_back(mk(1, 4'b0100, 1, 0,  1, 1, 2'd2, 0, 2'd0));
    tbl.push_back(mk(1, 4'b1000, 1, 0,  1, 1, 2'd3, 0, 2'd0));
    tbl.push_back(mk(0, 4'b0000, 1, 0,  1, 0, 2'd3, 0, 2'd0));
    // Malformed input
    tbl.push_back(mk(1, 4'b0000, 1, 0,  1, 1, 2'd0, 1, 2'd1));
    tbl.push_back(mk(1, 4'b0110, 1, 0,  1, 1, 2'd1, 1, 2'd2));
    tbl.push_back(mk(0, 4'b1111, 1, 0,  1, 0, 2'd1, 1, 2'd2));
    // Clear priority
    tbl.push_back(mk(1, 4'b0000, 1, 1,  1, 1, 2'd0, 1, 2'd1));
    tbl.push_back(mk(0, 4'b0000, 1, 1,  1, 0, 2'd0, 1, 2'd0));
    // Saturation
    tbl.push_back(mk(1, 4'b0000, 1, 0,  1, 1, 2'd0, 1, 2'd1));
    tbl.push_back(mk(1, 4'b1111, 1, 0,  1, 1, 2'd0, 1, 2'd2));
    tbl.push_back(mk(1, 4'b0101, 1, 0,  1, 1, 2'd0, 1, 2'd3));
    tbl.push_back(mk(1, 4'b0000, 1, 0,  1, 1, 2'd0, 1, 2'd3));
    tbl.push_back(mk(1, 4'b1100, 1, 0,  1, 1, 2'd2, 1, 2'd3));
    tbl.push_back(mk(1, 4'b0001, 1, 0,  1, 1, 2'd0, 0, 2'd3));
    tbl.push_back(mk(0, 4'b0000, 1, 1,  1, 0, 2'd0, 0, 2'd0));
    tbl.push_back(mk(1, 4'b1010, 1, 0,  1, 1, 2'd1, 1, 2'd1));
    tbl.push_back(mk(0, 4'b0000, 1, 1,  1, 0, 2'd1, 1, 2'd0));

    // Reset state, checked while rst is still high
    #1;
    chk_out("reset", 1'b0, 2'd0, 1'b0, 2'd0);
    chk("reset in_rdy", int'(bus.in_rdy), 1);
    chk("reset state", int'(dbg_state), int'(EMPTY));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].vld, tbl[i].d, tbl[i].ordy, tbl[i].clr);
      #1;
      chk($sformatf("v%0d in_rdy", i), int'(bus.in_rdy), int'(tbl[i].x_irdy));
      tick();
      chk_out($sformatf("v%0d", i), tbl[i].x_vld, tbl[i].x_code, tbl[i].x_err, tbl[i].x_cnt);
    end

    // Backpressure: 1000 held for 5 stalled cycles behind 0100
    drive(1, 4'b0100, 1, 0);
    tick();
    chk_out("bp load", 1'b1, 2'd2, 1'b0, 2'd0);
    drive(1, 4'b1000, 0, 0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d in_rdy", c), int'(bus.in_rdy), 0);
      tick();
      chk_out($sformatf("bp%0d", c), 1'b1, 2'd2, 1'b0, 2'd0);
    end
    drive(1, 4'b1000, 1, 0);
    #1;
    chk("bp release in_rdy", int'(bus.in_rdy), 1);
    tick();
    chk_out("bp release", 1'b1, 2'd3, 1'b0, 2'd0);
    drive(0, 4'b1000, 1, 0);
    tick();
    chk_out("bp drain", 1'b0, 2'd3, 1'b0, 2'd0);

    // A stalled malformed beat counts once, on acceptance
    drive(1, 4'b0001, 1, 0);
    tick();
    drive(1, 4'b0000, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out($sformatf("stall err%0d", c), 1'b1, 2'd0, 1'b0, 2'd0);
    end
    drive(1, 4'b0000, 1, 0);
    tick();
    chk_out("stall err accept", 1'b1, 2'd0, 1'b1, 2'd1);

    // Reset mid-operation: FULL, code 3, err_cnt 2
    drive(1, 4'b1000, 1, 0);
    tick();
    drive(1, 4'b0011, 1, 0);
    tick();
    drive(1, 4'b1000, 1, 0);
    tick();
    drive(0, 4'b0000, 0, 0);
    tick();
    chk_out("pre-reset", 1'b1, 2'd3, 1'b0, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async reset", 1'b0, 2'd0, 1'b0, 2'd0);
    chk("async reset state", int'(dbg_state), int'(EMPTY));
    tick();
    #2;
    rst = 1'b0;
    drive(1, 4'b0010, 1, 0);
    tick();
    chk_out("post-reset accept", 1'b1, 2'd1, 1'b0, 2'd0);
    drive(0, 4'b0000, 1, 0);
    tick();
    chk_out("post-reset drain", 1'b0, 2'd1, 1'b0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
